// File: rtl/mc_control.sv
// Multicycle CPU control FSM. It steps each instruction through fetch, decode, execute,
// memory and writeback states, and drives the ALU controls, operand selects and write enables.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_sel,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       halted
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_LI   = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_J    = 4'b1110;

  logic [3:0] state_q, state_d;
  logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!opcode[3]) begin
          state_d = S_EXEC_R;
        end else begin
          case (opcode)
            OP_NOP:        state_d = S_FETCH;
            OP_LI, OP_LUI: state_d = S_EXEC_I;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            default:       state_d = S_HALT;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU:   state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op      = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_sel     = 1'b0;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_read    = 1'b0;
    mem_write_s = 1'b0;
    iord        = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    pc_src      = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        alu_op     = OP_ADD;
        pc_write_s = mem_ready;
        ir_write_s = mem_ready;
      end
      // Branch target is precomputed into ALUOut while the opcode is decoded
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = OP_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = opcode;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = opcode;
        imm_sel   = (opcode == OP_LUI);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = OP_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        iord        = 1'b1;
      end
      S_WB_ALU: begin
        reg_write_s = 1'b1;
        reg_dst     = !opcode[3];
      end
      S_WB_MEM: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = OP_SUB;
        pc_src     = 2'b01;
        pc_write_s = alu_zero;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_s = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Reset gates the architectural write enables combinationally so an abort takes effect at once
  assign pc_write  = pc_write_s  & ~rst;
  assign ir_write  = ir_write_s  & ~rst;
  assign reg_write = reg_write_s & ~rst;
  assign mem_write = mem_write_s & ~rst;
  assign state     = state_q;

endmodule
